// File: rtl/reg_writeback_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : reg_writeback_pkg
//  Description : Shared types and constants for the write-back stage:
//                data width, register count, general/float file split,
//                the queued source-B payload and the write-port selector.
//  Revision    : 1.0  initial release
// ============================================================================
package reg_writeback_pkg;

    localparam int c_WIDTH      = 32;   // architectural data width
    localparam int c_NUM        = 64;   // 32 general + 32 float registers
    localparam int c_FLOAT_BASE = 32;   // float n lives at index 32+n
    localparam int c_NUM_W      = 5;    // register number width per file
    localparam int c_IDX_W      = 6;    // flat storage index width

    localparam logic c_GF_GENERAL = 1'b0;
    localparam logic c_GF_FLOAT   = 1'b1;

    // Source-B payload as it sits in the queue.
    typedef struct packed {
        logic               gfflag;
        logic [c_NUM_W-1:0] num;
        logic [c_WIDTH-1:0] data;
    } wb_entry_t;

    localparam int c_ENTRY_W = $bits(wb_entry_t);

    // Owner of the single write slot in the current cycle.
    typedef enum logic [1:0] {
        SEL_NONE = 2'd0,
        SEL_A    = 2'd1,
        SEL_B    = 2'd2
    } wb_sel_e;

    // The float file starts at 32, so the flat index is just {gfflag, num}.
    function automatic logic [c_IDX_W-1:0] reg_index(input logic gfflag,
                                                     input logic [c_NUM_W-1:0] num);
        return {gfflag, num};
    endfunction

    // General register 0 reads as zero forever; float 0 is ordinary.
    function automatic logic is_hardwired_zero(input logic gfflag,
                                               input logic [c_NUM_W-1:0] num);
        return (gfflag == c_GF_GENERAL) && (num == '0);
    endfunction

endpackage : reg_writeback_pkg
`default_nettype wire

// File: rtl/reg_writeback_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : reg_writeback_fifo  (wb_fifo)
//  Description : Small power-of-two queue holding source-B results until
//                they win the write port. No bypass: an entry pushed at an
//                edge is visible on o_head only after that edge.
//  Ports       : clk, rst         clock, async active-high reset
//                i_push, i_din    enqueue (caller guarantees !o_full)
//                i_pop            dequeue head (caller guarantees !o_empty)
//                o_head           current head payload
//                o_count          occupancy 0..DEPTH
//                o_full, o_empty  occupancy flags from registered state
//  Revision    : 1.0  initial release
// ============================================================================
module reg_writeback_fifo
    import reg_writeback_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_push,
    input  wb_entry_t                i_din,
    input  logic                     i_pop,
    output wb_entry_t                o_head,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_full,
    output logic                     o_empty
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;

    wb_entry_t            r_mem [DEPTH];
    logic [c_PTR_W-1:0]   r_wr_ptr;
    logic [c_PTR_W-1:0]   r_rd_ptr;
    logic [c_CNT_W-1:0]   r_count;

    logic                 w_do_push;
    logic                 w_do_pop;

    assign o_full  = (r_count == c_CNT_W'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_head  = r_mem[r_rd_ptr];

    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop  && !o_empty;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Payload storage needs no reset: it is only read when o_count says so.
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= i_din;
    end

endmodule : reg_writeback_fifo
`default_nettype wire

// File: rtl/reg_writeback.sv
`default_nettype none
// ============================================================================
//  Module      : reg_writeback
//  Description : Write-back stage owning 32 general + 32 float registers.
//                Merges a single-cycle source A and a queued long-latency
//                source B onto one write port; a starvation counter forces
//                the B head through after STARVE_LIMIT lost cycles.
//  Ports       : clk, rst                      clock, async active-high reset
//                a_valid/a_ready/a_gfflag/a_num/a_data   source A
//                b_valid/b_ready/b_gfflag/b_num/b_data   source B (queued)
//                regsout      flattened registers, general n at [32n],
//                             float n at [32(32+n)]
//                wb_valid/wb_gfflag/wb_num   registered record of last write
//                fifo_count   B queue occupancy
//  Revision    : 1.0  initial release
// ============================================================================
module reg_writeback
    import reg_writeback_pkg::*;
#(
    parameter int FIFO_DEPTH   = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          a_valid,
    output logic                          a_ready,
    input  logic                          a_gfflag,
    input  logic [c_NUM_W-1:0]            a_num,
    input  logic [c_WIDTH-1:0]            a_data,
    input  logic                          b_valid,
    output logic                          b_ready,
    input  logic                          b_gfflag,
    input  logic [c_NUM_W-1:0]            b_num,
    input  logic [c_WIDTH-1:0]            b_data,
    output logic [c_WIDTH*c_NUM-1:0]      regsout,
    output logic                          wb_valid,
    output logic                          wb_gfflag,
    output logic [c_NUM_W-1:0]            wb_num,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int              c_CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [c_CNT_W-1:0] c_LIMIT = c_CNT_W'(STARVE_LIMIT);

    // ------------------------------------------------------------------
    // Source-B queue
    // ------------------------------------------------------------------
    wb_entry_t  w_b_in;
    wb_entry_t  w_b_head;
    logic       w_fifo_full;
    logic       w_fifo_empty;
    logic       w_b_push;
    logic       w_b_pop;

    assign w_b_in   = '{gfflag: b_gfflag, num: b_num, data: b_data};
    // Ready depends only on registered occupancy: a full queue refuses even
    // when its head drains this cycle.
    assign b_ready  = !w_fifo_full;
    assign w_b_push = b_valid && b_ready;

    reg_writeback_fifo #(
        .DEPTH   (FIFO_DEPTH)
    ) u_wb_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_b_push),
        .i_din   (w_b_in),
        .i_pop   (w_b_pop),
        .o_head  (w_b_head),
        .o_count (fifo_count),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty)
    );

    // ------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------
    logic                r_force_b;
    logic [c_CNT_W-1:0]  r_starve_cnt;
    logic [c_CNT_W-1:0]  w_cnt_next;
    wb_sel_e             w_sel;
    wb_entry_t           w_wr;

    assign a_ready = !r_force_b;

    always_comb begin
        w_sel = SEL_NONE;
        if (r_force_b && !w_fifo_empty) w_sel = SEL_B;
        else if (a_valid)               w_sel = SEL_A;
        else if (!w_fifo_empty)         w_sel = SEL_B;
    end

    assign w_b_pop = (w_sel == SEL_B);

    always_comb begin
        w_wr = w_b_head;
        if (w_sel == SEL_A) w_wr = '{gfflag: a_gfflag, num: a_num, data: a_data};
    end

    // Counts cycles the B head sat waiting while A took the slot.
    always_comb begin
        w_cnt_next = r_starve_cnt;
        if (w_fifo_empty || (w_sel == SEL_B)) begin
            w_cnt_next = '0;
        end else if ((w_sel == SEL_A) && (r_starve_cnt != c_LIMIT)) begin
            w_cnt_next = r_starve_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_starve_cnt <= '0;
            r_force_b    <= 1'b0;
        end else begin
            r_starve_cnt <= w_cnt_next;
            r_force_b    <= (w_cnt_next == c_LIMIT);
        end
    end

    // ------------------------------------------------------------------
    // Register storage and write record
    // ------------------------------------------------------------------
    logic [c_WIDTH-1:0] r_regs [c_NUM];
    logic               r_wb_valid;
    logic               r_wb_gfflag;
    logic [c_NUM_W-1:0] r_wb_num;
    logic               w_wr_en;

    // A write to general 0 still uses the slot; it just lands nowhere.
    assign w_wr_en = (w_sel != SEL_NONE) && !is_hardwired_zero(w_wr.gfflag, w_wr.num);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < c_NUM; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_wr_en) begin
            r_regs[reg_index(w_wr.gfflag, w_wr.num)] <= w_wr.data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wb_valid  <= 1'b0;
            r_wb_gfflag <= 1'b0;
            r_wb_num    <= '0;
        end else begin
            r_wb_valid <= (w_sel != SEL_NONE);
            if (w_sel != SEL_NONE) begin
                r_wb_gfflag <= w_wr.gfflag;
                r_wb_num    <= w_wr.num;
            end
        end
    end

    assign wb_valid  = r_wb_valid;
    assign wb_gfflag = r_wb_gfflag;
    assign wb_num    = r_wb_num;

    generate
        for (genvar gi = 0; gi < c_NUM; gi++) begin : g_regsout
            assign regsout[gi*c_WIDTH +: c_WIDTH] = r_regs[gi];
        end
    endgenerate

endmodule : reg_writeback
`default_nettype wire

// File: tb/tb_reg_writeback.sv
`default_nettype none
// ============================================================================
//  Module      : tb_reg_writeback
//  Description : Directed self-checking bench for reg_writeback.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_reg_writeback;
    import reg_writeback_pkg::*;

    localparam int FIFO_DEPTH   = 2;
    localparam int STARVE_LIMIT = 4;

    logic                         clk;
    logic                         rst;
    logic                         a_valid, a_ready, a_gfflag;
    logic [4:0]                   a_num;
    logic [31:0]                  a_data;
    logic                         b_valid, b_ready, b_gfflag;
    logic [4:0]                   b_num;
    logic [31:0]                  b_data;
    logic [32*64-1:0]             regsout;
    logic                         wb_valid, wb_gfflag;
    logic [4:0]                   wb_num;
    logic [$clog2(FIFO_DEPTH):0]  fifo_count;

    int n_cmp;
    int n_err;

    reg_writeback #(
        .FIFO_DEPTH   (FIFO_DEPTH),
        .STARVE_LIMIT (STARVE_LIMIT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .a_valid    (a_valid),
        .a_ready    (a_ready),
        .a_gfflag   (a_gfflag),
        .a_num      (a_num),
        .a_data     (a_data),
        .b_valid    (b_valid),
        .b_ready    (b_ready),
        .b_gfflag   (b_gfflag),
        .b_num      (b_num),
        .b_data     (b_data),
        .regsout    (regsout),
        .wb_valid   (wb_valid),
        .wb_gfflag  (wb_gfflag),
        .wb_num     (wb_num),
        .fifo_count (fifo_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // General n at flat index n, float n at 32+n.
    function automatic logic [31:0] rd(input int idx);
        return regsout[idx*32 +: 32];
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst = 1'b1;
        a_valid = 0; a_gfflag = 0; a_num = 0; a_data = 0;
        b_valid = 0; b_gfflag = 0; b_num = 0; b_data = 0;

        // ---------------- reset state ----------------
        step();
        check_eq("rst_regsout_zero", {63'd0, |regsout}, 64'd0);
        check_eq("rst_fifo_count",   64'(fifo_count),   64'd0);
        check_eq("rst_wb_valid",     64'(wb_valid),     64'd0);
        check_eq("rst_b_ready",      64'(b_ready),      64'd1);
        check_eq("rst_a_ready",      64'(a_ready),      64'd1);
        #2 rst = 1'b0;
        step();

        // ---------------- A write general 5 ----------------
        a_valid = 1; a_gfflag = 0; a_num = 5; a_data = 32'hDEADBEEF;
        step();
        check_eq("a_g5_data",   64'(regsout[191:160]), 64'hDEADBEEF);
        check_eq("a_g5_wbv",    64'(wb_valid),         64'd1);
        check_eq("a_g5_wbnum",  64'(wb_num),           64'd5);
        check_eq("a_g5_wbgf",   64'(wb_gfflag),        64'd0);
        a_valid = 0;
        step();
        check_eq("idle_wbv",    64'(wb_valid),         64'd0);

        // ---------------- r0 guard ----------------
        a_valid = 1; a_gfflag = 0; a_num = 0; a_data = 32'h0000_1234;
        step();
        check_eq("g0_stays_zero", 64'(rd(0)),    64'd0);
        check_eq("g0_wbv",        64'(wb_valid), 64'd1);
        check_eq("g0_wbnum",      64'(wb_num),   64'd0);
        a_gfflag = 1; a_num = 0; a_data = 32'h3F80_0000;
        step();
        check_eq("f0_written",    64'(rd(32)),   64'h3F800000);
        check_eq("f0_wbgf",       64'(wb_gfflag),64'd1);
        a_valid = 0;
        step();

        // ---------------- idle drain of one B entry ----------------
        b_valid = 1; b_gfflag = 1; b_num = 7; b_data = 32'h4049_0FDB;
        step();
        b_valid = 0;
        check_eq("drain_cnt_after_push", 64'(fifo_count), 64'd1);
        check_eq("drain_no_bypass",      64'(rd(39)),     64'd0);
        check_eq("drain_wbv_push_cycle", 64'(wb_valid),   64'd0);
        step();
        check_eq("drain_f7_data",  64'(rd(39)),     64'h40490FDB);
        check_eq("drain_cnt_zero", 64'(fifo_count), 64'd0);
        check_eq("drain_wbv",      64'(wb_valid),   64'd1);
        check_eq("drain_wbnum",    64'(wb_num),     64'd7);
        check_eq("drain_wbgf",     64'(wb_gfflag),  64'd1);

        // ---------------- starvation guard and full queue ----------------
        // Cycle k: A always valid to g10 with data 0x100+k. B pushes g20 at
        // k=0, g21 at k=1; a third push at k=5 must bounce off a full queue.
        a_valid = 1; a_gfflag = 0; a_num = 10;
        for (int k = 0; k <= 10; k++) begin
            logic [1:0] exp_cnt;
            a_data  = 32'h100 + 32'(k);
            b_valid = (k == 0) || (k == 1) || (k == 5);
            b_gfflag = 0;
            b_num   = (k == 0) ? 5'd20 : (k == 1) ? 5'd21 : 5'd22;
            b_data  = (k == 0) ? 32'hAAAA0001 : (k == 1) ? 32'hBBBB0002 : 32'hCCCC0003;
            exp_cnt = (k == 0) ? 2'd0 : (k == 1) ? 2'd1 : (k <= 5) ? 2'd2 : 2'd1;
            #1;
            check_eq($sformatf("starve_a_ready_k%0d", k), 64'(a_ready),
                     ((k == 5) || (k == 10)) ? 64'd0 : 64'd1);
            check_eq($sformatf("starve_cnt_k%0d", k), 64'(fifo_count), 64'(exp_cnt));
            check_eq($sformatf("starve_b_ready_k%0d", k), 64'(b_ready),
                     ((k >= 2) && (k <= 5)) ? 64'd0 : 64'd1);
            step();
            if (k == 4) begin
                check_eq("starve_g10_k4", 64'(rd(10)),  64'h104);
                check_eq("starve_wbnum_k4", 64'(wb_num), 64'd10);
            end
            if (k == 5) begin
                check_eq("forced_g20",       64'(rd(20)),      64'hAAAA0001);
                check_eq("forced_wbnum_20",  64'(wb_num),      64'd20);
                check_eq("full_no_passthru", 64'(fifo_count),  64'd1);
            end
            if (k == 10) begin
                check_eq("forced_g21",      64'(rd(21)),     64'hBBBB0002);
                check_eq("forced_wbnum_21", 64'(wb_num),     64'd21);
                check_eq("starve_cnt_end",  64'(fifo_count), 64'd0);
            end
        end
        a_valid = 0; b_valid = 0;
        step();
        check_eq("g22_never_written", 64'(rd(22)),     64'd0);
        check_eq("g10_last_a",        64'(rd(10)),     64'h109);
        check_eq("empty_idle_wbv",    64'(wb_valid),   64'd0);

        // ---------------- async reset with B entries queued ----------------
        a_valid = 1; a_gfflag = 0; a_num = 11; a_data = 32'h5555_AAAA;
        b_valid = 1; b_num = 23; b_data = 32'h1111_2222;
        step();
        b_num = 24; b_data = 32'h3333_4444;
        step();
        b_valid = 0;
        check_eq("pre_rst_cnt", 64'(fifo_count), 64'd2);
        #2 rst = 1'b1;
        #1;
        check_eq("async_rst_regsout", {63'd0, |regsout}, 64'd0);
        check_eq("async_rst_cnt",     64'(fifo_count),   64'd0);
        check_eq("async_rst_wbv",     64'(wb_valid),     64'd0);
        check_eq("async_rst_b_ready", 64'(b_ready),      64'd1);
        check_eq("async_rst_wbnum",   64'(wb_num),       64'd0);
        a_valid = 0;
        step();
        rst = 1'b0;
        step();
        step();
        check_eq("post_rst_cnt", 64'(fifo_count), 64'd0);
        check_eq("post_rst_wbv", 64'(wb_valid),   64'd0);
        check_eq("post_rst_g23", 64'(rd(23)),     64'd0);
        check_eq("post_rst_g11", 64'(rd(11)),     64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_reg_writeback
`default_nettype wire

// File: doc/reg_writeback.md
Name: reg_writeback

Overview:
- Write-back stage that owns the architectural register storage.
- Storage is 32 general plus 32 float registers. It drives the flattened regsout bus that reg_reader consumes.
- Merges two result sources onto one write port:
  - source A: single-cycle integer/exec pipe, direct.
  - source B: long-latency FPU/memory pipe, through a small FIFO.
- Starvation guard guarantees source B forward progress.

Parameters:
- FIFO_DEPTH, 2, entries in the source-B queue (power of two, >=2).
- STARVE_LIMIT, 4, consecutive cycles B head may lose arbitration before it is forced.
- Data width and register count are the shared header macros `WIDTH (32) and `NUM (64). They are not module parameters.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rst  in  1  asynchronous, active-high reset.
- a_valid  in  1  source A result valid.
- a_ready  out  1  source A accepted this cycle when a_valid&&a_ready.
- a_gfflag  in  1  0: general, 1: float.
- a_num  in  5  destination register number.
- a_data  in  `WIDTH  result value.
- b_valid  in  1  source B result valid.
- b_ready  out  1  source B enqueued when b_valid&&b_ready.
- b_gfflag  in  1  0: general, 1: float.
- b_num  in  5  destination register number.
- b_data  in  `WIDTH  result value.
- regsout  out  `WIDTH*`NUM  flattened register contents.
- wb_valid  out  1  registered pulse: a write slot was used last cycle.
- wb_gfflag  out  1  file of the last write.
- wb_num  out  5  register number of the last write.
- fifo_count  out  log2(FIFO_DEPTH)+1  current B queue occupancy.

Behaviour:
- Reset is asynchronous and active-high, on rst. While rst=1 or after it:
  - all 64 registers = 0, so regsout = 0;
  - FIFO empty, fifo_count=0;
  - starve counter=0, force_b=0;
  - wb_valid=0, wb_gfflag=0, wb_num=0.
- Reset mid-operation discards queued B entries and any in-flight write; no partial write is retained.
- Register mapping:
  - general n occupies regsout[`WIDTH*n +: `WIDTH];
  - float n occupies regsout[`WIDTH*(32+n) +: `WIDTH].
- General register 0 is hardwired zero. Writes to it consume a slot and pulse wb_valid, but storage is unchanged. Float register 0 is ordinary.
- Source B queue:
  - b_ready = (fifo_count != FIFO_DEPTH), combinational from registered state only.
  - When full, b_ready=0 even if the head is popped the same cycle; there is no pass-through.
  - An entry enqueued at edge t is eligible for write no earlier than the cycle after t; there is no bypass from b_* to storage.
  - Push and pop in the same cycle leave fifo_count unchanged; pointers wrap modulo FIFO_DEPTH.
- Arbitration, one write per cycle, evaluated combinationally:
  1. force_b && fifo nonempty: write B head, pop; a_ready=0.
  2. else a_valid: write A; a_ready=1.
  3. else fifo nonempty: write B head, pop.
  4. else no write.
- a_ready = !force_b. A is never stalled otherwise.
- Starve counter:
  - increments when the fifo is nonempty and A wins the slot;
  - clears when B head is written or the fifo is empty;
  - force_b = (counter == STARVE_LIMIT), registered;
  - force_b holds exactly one cycle, because the forced B write clears the counter.
- Latency:
  - a write accepted at edge t is visible on regsout after edge t;
  - reg_reader's registered read then makes the data available after edge t+1.
- wb_valid, wb_gfflag and wb_num register the selected write at the same edge.
- Ordering between A and B writes to the same register is not arbitrated here. The issue-stage scoreboard must prevent WAW hazards across sources. Within B, FIFO order is preserved.

Decomposition:
- `WIDTH, `NUM, the register-file split offset (32) and gfflag encoding stay in common.h.
- One sub-module: wb_fifo, a parameterised FIFO_DEPTH queue.
  - Payload: {gfflag, num[4:0], data}.
  - Ports: push/pop, head, count, full/empty.
- Arbitration, starve counter and storage stay in reg_writeback.

Test Plan:
- Reset: assert rst mid-stream with 2 B entries queued -> regsout=0, fifo_count=0, wb_valid=0, b_ready=1 immediately (async).
- A write: a_valid, gfflag=0, num=5, data=32'hDEADBEEF -> after edge, regsout[191:160]=32'hDEADBEEF, wb_valid=1, wb_num=5.
- r0 guard:
  - A write general 0 with 32'h1234 -> regsout[31:0] stays 0, wb_valid=1;
  - float 0 with 32'h3F800000 -> regsout[`WIDTH*32 +: 32]=32'h3F800000.
- FIFO full: hold a_valid=1 continuously, push 2 B entries -> b_ready=0 while fifo_count=2. B only drains via forced slots.
- Starvation: a_valid=1 every cycle, one B entry queued -> A wins 4 cycles, then a_ready=0 for one cycle and B writes, then a_ready=1. The pattern repeats per B entry.
- Idle drain: a_valid=0, B enqueues float 7 = 32'h40490FDB at edge t -> written at edge t+1, regsout float 7 updated, fifo_count back to 0.
